// File: rtl/f_nextpc.sv
// f_nextpc: fetch-stage next-PC generator for the dual-issue front end.
// Holds the fetch PC of an instruction pair (pc, pc+1) and predicts the next
// fetch PC using a direct-mapped BTB with 2-bit saturating counters. The BTB
// is trained by E-stage branch/jalr resolutions and by D-stage jal mispredicts.
// E-stage and D-stage redirects override the prediction and any stall.
module f_nextpc #(
  parameter int          IDX_W    = 5,
  parameter logic [12:0] RESET_PC = 13'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic [12:0] pc,
  output logic [12:0] pc_pred,
  output logic [1:0]  pred_slot,
  input  logic        d_fail,
  input  logic [12:0] d_pc,
  input  logic [12:0] d_true_pc,
  input  logic        e_valid,
  input  logic [12:0] e_pc,
  input  logic        e_taken,
  input  logic [12:0] e_target,
  input  logic        e_fail,
  input  logic [12:0] e_true_pc
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 13 - IDX_W;

  // Only the valid bits are reset; the payload arrays are plain storage.
  logic [ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]   btb_tag    [ENTRIES];
  logic [12:0]        btb_target [ENTRIES];
  logic [1:0]         btb_cnt    [ENTRIES];

  logic [12:0]      pc_s1;
  logic [IDX_W-1:0] idx0;
  logic [IDX_W-1:0] idx1;
  logic             hit0;
  logic             hit1;
  logic             taken0;
  logic             taken1;

  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             e_hit;
  logic             e_we;
  logic [1:0]       e_old_cnt;
  logic [1:0]       e_new_cnt;
  logic [12:0]      e_new_target;

  logic [IDX_W-1:0] d_idx;
  logic [TAG_W-1:0] d_tag;
  logic             d_we;

  assign pc_s1 = pc + 13'd1;
  assign idx0  = pc[IDX_W-1:0];
  assign idx1  = pc_s1[IDX_W-1:0];

  // Lookup both slots of the current pair and choose the next fetch PC.
  always_comb begin
    hit0      = btb_valid[idx0] && (btb_tag[idx0] == pc[12:IDX_W]);
    hit1      = btb_valid[idx1] && (btb_tag[idx1] == pc_s1[12:IDX_W]);
    taken0    = hit0 && btb_cnt[idx0][1];
    taken1    = hit1 && btb_cnt[idx1][1];
    pc_pred   = pc + 13'd2;
    pred_slot = 2'b00;
    if (taken0) begin
      pc_pred   = btb_target[idx0];
      pred_slot = 2'b01;
    end else if (taken1) begin
      pc_pred   = btb_target[idx1];
      pred_slot = 2'b10;
    end
  end

  // Decode the E-stage and D-stage training writes; E wins an index collision.
  always_comb begin
    e_idx        = e_pc[IDX_W-1:0];
    e_tag        = e_pc[12:IDX_W];
    e_hit        = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);
    e_old_cnt    = btb_cnt[e_idx];
    e_we         = e_valid && (e_hit || e_taken);
    e_new_cnt    = 2'b10;
    e_new_target = e_target;
    if (e_hit) begin
      if (e_taken) begin
        e_new_cnt = (e_old_cnt == 2'b11) ? 2'b11 : e_old_cnt + 2'd1;
      end else begin
        e_new_cnt    = (e_old_cnt == 2'b00) ? 2'b00 : e_old_cnt - 2'd1;
        e_new_target = btb_target[e_idx];
      end
    end
    d_idx = d_pc[IDX_W-1:0];
    d_tag = d_pc[12:IDX_W];
    d_we  = d_fail && !(e_we && (e_idx == d_idx));
  end

  // Fetch PC register: E redirect, then D redirect, then stall, then prediction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (e_fail) begin
      pc <= e_true_pc;
    end else if (d_fail) begin
      pc <= d_true_pc;
    end else if (!stall) begin
      pc <= pc_pred;
    end
  end

  // Valid bits: cleared by reset, set by any training write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_valid <= '0;
    end else begin
      if (e_we) btb_valid[e_idx] <= 1'b1;
      if (d_we) btb_valid[d_idx] <= 1'b1;
    end
  end

  // BTB payload writes; suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (e_we) begin
        btb_tag[e_idx]    <= e_tag;
        btb_target[e_idx] <= e_new_target;
        btb_cnt[e_idx]    <= e_new_cnt;
      end
      if (d_we) begin
        btb_tag[d_idx]    <= d_tag;
        btb_target[d_idx] <= d_true_pc;
        btb_cnt[d_idx]    <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_f_nextpc.sv
// tb_f_nextpc: scoreboard bench for f_nextpc. The stimulus process drives
// inputs just after each rising edge and queues the outputs expected for that
// cycle; a monitor on the falling edge pops and compares them.
module tb_f_nextpc;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [12:0] pc;
  logic [12:0] pc_pred;
  logic [1:0]  pred_slot;
  logic        d_fail;
  logic [12:0] d_pc;
  logic [12:0] d_true_pc;
  logic        e_valid;
  logic [12:0] e_pc;
  logic        e_taken;
  logic [12:0] e_target;
  logic        e_fail;
  logic [12:0] e_true_pc;

  typedef struct {
    string       name;
    logic [12:0] pc;
    logic [12:0] pred;
    logic [1:0]  slot;
  } exp_t;

  exp_t expq[$];
  int   checks;
  int   failures;

  f_nextpc #(.IDX_W(5), .RESET_PC(13'd0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .pc        (pc),
    .pc_pred   (pc_pred),
    .pred_slot (pred_slot),
    .d_fail    (d_fail),
    .d_pc      (d_pc),
    .d_true_pc (d_true_pc),
    .e_valid   (e_valid),
    .e_pc      (e_pc),
    .e_taken   (e_taken),
    .e_target  (e_target),
    .e_fail    (e_fail),
    .e_true_pc (e_true_pc)
  );

  // 10-unit clock period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compare the DUT outputs against the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (pc !== e.pc || pc_pred !== e.pred || pred_slot !== e.slot) begin
        failures++;
        $display("[TB] FAIL %s: got pc=%0d pc_pred=%0d pred_slot=%b, expected pc=%0d pc_pred=%0d pred_slot=%b",
                 e.name, pc, pc_pred, pred_slot, e.pc, e.pred, e.slot);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [12:0] exp_pc,
                             input logic [12:0] exp_pred, input logic [1:0] exp_slot);
    exp_t e;
    e.name = name;
    e.pc   = exp_pc;
    e.pred = exp_pred;
    e.slot = exp_slot;
    expq.push_back(e);
  endtask

  task automatic applyStimulus(input logic st,
                               input logic df, input logic [12:0] dpc, input logic [12:0] dtrue,
                               input logic ev, input logic [12:0] epc, input logic et,
                               input logic [12:0] etgt,
                               input logic ef, input logic [12:0] etrue);
    stall     = st;
    d_fail    = df;
    d_pc      = dpc;
    d_true_pc = dtrue;
    e_valid   = ev;
    e_pc      = epc;
    e_taken   = et;
    e_target  = etgt;
    e_fail    = ef;
    e_true_pc = etrue;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redirect(input logic [12:0] target);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, target);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle();

    // Reset and free-running fetch
    tick(); tick();
    checkOutput("reset_state", 13'd0, 13'd2, 2'b00);
    rst_n = 1'b1;
    tick(); checkOutput("free_pc2", 13'd2, 13'd4, 2'b00);
    tick(); checkOutput("free_pc4", 13'd4, 13'd6, 2'b00);
    tick(); checkOutput("free_pc6", 13'd6, 13'd8, 2'b00);

    // D-stage jal training and redirect
    applyStimulus(0, 1, 13'd4, 13'd100, 0, 0, 0, 0, 0, 0);
    tick(); checkOutput("d_redirect", 13'd100, 13'd102, 2'b00);
    redirect(13'd4);
    tick(); checkOutput("slot0_hit", 13'd4, 13'd100, 2'b01);
    redirect(13'd3);
    tick(); checkOutput("slot1_hit", 13'd3, 13'd100, 2'b10);
    idle();
    tick(); checkOutput("follow_slot1", 13'd100, 13'd102, 2'b00);

    // E-stage allocate and counter training
    applyStimulus(0, 0, 0, 0, 1, 13'd8, 1, 13'd40, 0, 0);
    tick(); checkOutput("e_alloc_cycle", 13'd102, 13'd104, 2'b00);
    redirect(13'd8);
    tick(); checkOutput("e_alloc_cnt10", 13'd8, 13'd40, 2'b01);
    applyStimulus(1, 0, 0, 0, 1, 13'd8, 0, 13'd0, 0, 0);
    tick(); checkOutput("cnt_down_01", 13'd8, 13'd10, 2'b00);
    applyStimulus(1, 0, 0, 0, 1, 13'd8, 1, 13'd40, 0, 0);
    tick(); checkOutput("cnt_up_10", 13'd8, 13'd40, 2'b01);
    tick(); checkOutput("cnt_up_11", 13'd8, 13'd40, 2'b01);
    applyStimulus(1, 0, 0, 0, 1, 13'd8, 1, 13'd44, 0, 0);
    tick(); checkOutput("cnt_sat_11_tgt", 13'd8, 13'd44, 2'b01);
    applyStimulus(1, 0, 0, 0, 1, 13'd8, 0, 13'd0, 0, 0);
    tick(); checkOutput("cnt_down_10", 13'd8, 13'd44, 2'b01);
    tick(); checkOutput("cnt_down_01b", 13'd8, 13'd10, 2'b00);
    idle();
    tick(); checkOutput("after_train", 13'd10, 13'd12, 2'b00);

    // Simultaneous E and D writes to index 3: E wins
    applyStimulus(0, 1, 13'd35, 13'd300, 1, 13'd3, 1, 13'd200, 1, 13'd200);
    tick(); checkOutput("e_over_d_pc", 13'd200, 13'd202, 2'b00);
    redirect(13'd3);
    tick(); checkOutput("e_entry_kept", 13'd3, 13'd200, 2'b01);
    redirect(13'd35);
    tick(); checkOutput("d_write_dropped", 13'd35, 13'd37, 2'b00);

    // Stall, and a redirect overriding stall
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 13'd20);
    tick(); checkOutput("stall_enter", 13'd20, 13'd22, 2'b00);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); checkOutput("stall_1", 13'd20, 13'd22, 2'b00);
    tick(); checkOutput("stall_2", 13'd20, 13'd22, 2'b00);
    tick(); checkOutput("stall_3", 13'd20, 13'd22, 2'b00);
    applyStimulus(1, 1, 13'd60, 13'd50, 0, 0, 0, 0, 0, 0);
    tick(); checkOutput("d_over_stall", 13'd50, 13'd52, 2'b00);
    idle();
    tick(); checkOutput("unstall", 13'd52, 13'd54, 2'b00);

    // PC wrap-around
    redirect(13'd8191);
    tick(); checkOutput("wrap_8191", 13'd8191, 13'd1, 2'b00);
    idle();
    tick(); checkOutput("wrap_follow", 13'd1, 13'd3, 2'b00);
    redirect(13'd8190);
    tick(); checkOutput("wrap_8190", 13'd8190, 13'd0, 2'b00);

    // Mid-cycle reset clears the BTB and blocks training
    redirect(13'd4);
    tick(); checkOutput("pre_reset_hit", 13'd4, 13'd100, 2'b01);
    idle();
    tick();
    #2;
    rst_n = 1'b0;
    applyStimulus(0, 1, 13'd13, 13'd88, 1, 13'd12, 1, 13'd77, 0, 0);
    #1;
    checkOutput("async_reset", 13'd0, 13'd2, 2'b00);
    tick(); tick();
    idle();
    rst_n = 1'b1;
    tick(); checkOutput("post_reset", 13'd2, 13'd4, 2'b00);
    redirect(13'd4);
    tick(); checkOutput("btb_cleared_4", 13'd4, 13'd6, 2'b00);
    redirect(13'd12);
    tick(); checkOutput("no_train_in_reset", 13'd12, 13'd14, 2'b00);
    redirect(13'd60);
    tick(); checkOutput("btb_cleared_60", 13'd60, 13'd62, 2'b00);
    idle();
    tick(); tick();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    if (expq.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", expq.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/f_nextpc.md
Name: f_nextpc

Overview:
- Fetch-stage next-PC generator and branch predictor for the dual-issue pipeline.
- Each cycle it holds the fetch PC for an instruction pair (word addresses pc, pc+1) and predicts the next fetch PC using a direct-mapped BTB with 2-bit saturating counters.
- It takes redirects from the D stage (jal target mismatch: d_fail, d_true_pc) and from the E stage (branch/jalr resolution), and trains the BTB from both.
- Its pc_pred output is the pc_predicted that the D/E stages later check.

Parameters:
- IDX_W, 5, BTB index width; ENTRIES = 2^IDX_W.
- RESET_PC, 13'd0, word PC loaded on reset.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold fetch PC (pipeline stall)
- pc  output  13  current fetch word PC (slot1 = pc+1)
- pc_pred  output  13  predicted next fetch PC
- pred_slot  output  2  01: slot0 predicted taken, 10: slot1 predicted taken, 00: none
- d_fail  input  1  D-stage jal mispredict
- d_pc  input  13  PC of the D-stage jal
- d_true_pc  input  13  correct jal target
- e_valid  input  1  E-stage branch/jalr resolved this cycle
- e_pc  input  13  PC of the resolved instruction
- e_taken  input  1  actual direction
- e_target  input  13  actual taken target
- e_fail  input  1  E-stage mispredict (redirect required)
- e_true_pc  input  13  correct next PC after e_fail

Behaviour:
- BTB entry fields: valid, tag (13-IDX_W bits, pc[12:IDX_W]), target[12:0], cnt[1:0]. The index is pc[IDX_W-1:0].
- Only the valid bits are cleared by reset. Tag, target and cnt arrays are not reset.
- Lookup is combinational from the pc register, for slot0 = pc and slot1 = pc+1 (mod 2^13). A slot hits when valid is set and the tag matches; it predicts taken when it hits and cnt[1]=1.
- Prediction:
  - slot0 taken: pc_pred = target0, pred_slot = 01.
  - else slot1 taken: pc_pred = target1, pred_slot = 10.
  - else pc_pred = pc+2 (mod 2^13, wraps 8190->0, 8191->1), pred_slot = 00.
- The pc register update on each posedge follows this priority:
  1. e_fail: pc <= e_true_pc.
  2. d_fail: pc <= d_true_pc.
  3. stall: pc holds.
  4. otherwise pc <= pc_pred.
- Redirects override stall.
- Redirect latency is 1 cycle: the redirected PC appears on pc the cycle after d_fail/e_fail is sampled.
- E training, when e_valid is high at the posedge:
  - Hit: cnt saturates up if e_taken, down if not (11 stays 11, 00 stays 00). target <= e_target when e_taken.
  - Miss and e_taken: allocate with valid=1, tag, target=e_target, cnt=10.
  - Miss and not taken: no write.
- D training, when d_fail is high: write the entry for d_pc with valid=1, tag, target=d_true_pc, cnt=11.
- Simultaneous E and D writes to the same index: only the E write occurs. Writes to different indices both occur.
- A BTB write becomes visible to lookup in the next cycle. A lookup in the same cycle as a write sees the old contents.
- Reset asserted at any time:
  - Outputs immediately go to pc = RESET_PC, pc_pred = RESET_PC+2, pred_slot = 00.
  - All valid bits are cleared.
  - No training occurs while rst_n = 0.
- On release of reset, fetch resumes from RESET_PC on the next edge.
- pc_pred and pred_slot are purely combinational from pc and the BTB state. They are still driven while stall is high.

Test Plan:
- Reset with RESET_PC=0, then 3 free cycles with no stall -> pc sequence 0, 2, 4, 6; pred_slot=00 throughout.
- d_fail with d_pc=4 and d_true_pc=100 -> next cycle pc=100. After a later redirect to pc=4: pc_pred=100, pred_slot=01. At pc=3: slot1 hits and pred_slot=10, pc_pred=100.
- e_valid with e_pc=8, e_taken=1, e_target=40 (miss) -> cnt=10. Then e_taken=0 at pc 8 -> cnt=01 and lookup at pc=8 gives pc_pred=10. Three taken updates -> cnt saturates at 11 and stays 11.
- Same cycle: e_fail with e_true_pc=200 and d_fail with d_true_pc=300, both PCs at index 3 -> pc=200 next. The entry holds the E data; the D write is dropped.
- stall=1 for 3 cycles at pc=20 -> pc stays 20. A d_fail during the stall with d_true_pc=50 -> pc=50 next cycle despite stall.
- pc=8191 with an empty BTB -> slot1 looks up 0 and pc_pred=1. Asserting rst_n=0 mid-cycle -> pc=RESET_PC immediately and all prior BTB hits are gone.
